// File: rtl/pipeline_debug_ctrl.sv
// Debug controller for a pipelined CPU: UART commands run, step, halt, reset and dump the PC.
// Optional macro DEBUG_CYCLE_COUNT_EN adds a 32-bit run-cycle counter that is appended to each dump.
module pipeline_debug_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  input  logic        halt_wb,
  input  logic [31:0] pc_value,
  output logic        pipe_en,
  output logic        pipe_rst,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        done
);

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int NBYTES = 8;
`else
  localparam int NBYTES = 4;
`endif
  localparam int SW = NBYTES * 8;

  localparam logic [7:0] CMD_C = 8'h63;
  localparam logic [7:0] CMD_S = 8'h73;
  localparam logic [7:0] CMD_H = 8'h68;
  localparam logic [7:0] CMD_R = 8'h72;
  localparam logic [7:0] CMD_D = 8'h64;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_SEND = 2'd3} state_e;
  typedef enum logic [1:0] {P_ISSUE = 2'd0, P_WAIT_HI = 2'd1, P_WAIT_LO = 2'd2} phase_e;

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [2:0]      idx_q, idx_d;
  logic [SW-1:0]   snap_q, snap_d;
  logic            pipe_en_q, pipe_en_d;
  logic            pipe_rst_q, pipe_rst_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            done_q, done_d;
`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0]     cnt_q, cnt_d;
`endif

  // Byte idx of the snapshot, counted from the most significant end.
  function automatic logic [7:0] byte_sel(input logic [SW-1:0] s, input logic [2:0] i);
    logic [SW-1:0] sh;
    sh = s << {i, 3'b000};
    return sh[SW-1 -: 8];
  endfunction

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    pipe_rst_d = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    done_d     = done_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_C: if (!done_q) state_d = S_RUN;  else state_d = S_IDLE;
            CMD_S: if (!done_q) state_d = S_STEP; else state_d = S_IDLE;
            CMD_R: begin
              pipe_rst_d = 1'b1;
              done_d     = 1'b0;
            end
            CMD_D: begin
`ifdef DEBUG_CYCLE_COUNT_EN
              snap_d = {pc_value, cnt_q};
`else
              snap_d = pc_value;
`endif
              idx_d   = 3'd0;
              phase_d = P_ISSUE;
              state_d = S_SEND;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // A halt reaching writeback outranks any command arriving alongside it.
        if (halt_wb) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (rx_valid) begin
          case (rx_data)
            CMD_H: state_d = S_IDLE;
            CMD_R: begin
              pipe_rst_d = 1'b1;
              done_d     = 1'b0;
              state_d    = S_IDLE;
            end
            default: state_d = S_RUN;
          endcase
        end else begin
          state_d = S_RUN;
        end
      end
      S_STEP: begin
        if (halt_wb) done_d = 1'b1; else done_d = done_q;
        state_d = S_IDLE;
      end
      S_SEND: begin
        case (phase_q)
          P_ISSUE: begin
            if (!tx_busy) begin
              tx_start_d = 1'b1;
              tx_data_d  = byte_sel(snap_q, idx_q);
              phase_d    = P_WAIT_HI;
            end else begin
              phase_d = P_ISSUE;
            end
          end
          P_WAIT_HI: if (tx_busy) phase_d = P_WAIT_LO; else phase_d = P_WAIT_HI;
          P_WAIT_LO: begin
            if (!tx_busy) begin
              phase_d = P_ISSUE;
              if (idx_q == 3'(NBYTES - 1)) begin
                idx_d   = 3'd0;
                state_d = S_IDLE;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end else begin
              phase_d = P_WAIT_LO;
            end
          end
          default: phase_d = P_ISSUE;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    pipe_en_d = (state_d == S_RUN) || (state_d == S_STEP);
  end

`ifdef DEBUG_CYCLE_COUNT_EN
  // Cycle counter: cleared together with the pipeline reset pulse.
  always_comb begin
    if (pipe_rst_d)     cnt_d = 32'd0;
    else if (pipe_en_q) cnt_d = cnt_q + 32'd1;
    else                cnt_d = cnt_q;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      phase_q    <= P_ISSUE;
      idx_q      <= 3'd0;
      snap_q     <= '0;
      pipe_en_q  <= 1'b0;
      pipe_rst_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      done_q     <= 1'b0;
`ifdef DEBUG_CYCLE_COUNT_EN
      cnt_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      pipe_en_q  <= pipe_en_d;
      pipe_rst_q <= pipe_rst_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
`ifdef DEBUG_CYCLE_COUNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign pipe_en  = pipe_en_q;
  assign pipe_rst = pipe_rst_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Self-checking bench for pipeline_debug_ctrl; dump bytes are checked through a scoreboard queue.
// Honours DEBUG_CYCLE_COUNT_EN (8-byte dumps carrying a modelled cycle count).
module tb_pipeline_debug_ctrl;

`ifdef DEBUG_CYCLE_COUNT_EN
  localparam int NB = 8;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic        halt_wb = 1'b0;
  logic [31:0] pc_value = 32'h0;
  logic        pipe_en, pipe_rst, tx_start, done;
  logic [7:0]  tx_data;

  int pass_cnt = 0;
  int total_cnt = 0;
  int bytes_seen = 0;
  int busy_cnt = 0;
  logic [31:0] model_cnt = 32'd0;
  logic [7:0] exp_q[$];

  pipeline_debug_ctrl dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .halt_wb(halt_wb), .pc_value(pc_value),
    .pipe_en(pipe_en), .pipe_rst(pipe_rst), .tx_data(tx_data),
    .tx_start(tx_start), .done(done)
  );

  always #5 clk = ~clk;

  // UART model (busy for 20 cycles per start), scoreboard pop, run-cycle model.
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      bytes_seen++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL tx_unexpected: tx_start with data %02h, no byte expected", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) $display("FAIL tx_byte: got %02h, expected %02h", tx_data, e);
        else pass_cnt++;
      end
      busy_cnt = 20;
    end
    tx_busy = (busy_cnt != 0);
    if (busy_cnt > 0) busy_cnt--;
    if (pipe_en === 1'b1) model_cnt = model_cnt + 32'd1;
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %b, expected %b", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic push_dump(input logic [31:0] pc);
    logic [63:0] v;
    v = {pc, model_cnt};
    for (int i = 0; i < NB; i++) exp_q.push_back(v[63-8*i -: 8]);
  endtask

  task automatic test_reset;
    #1;
    total_cnt++;
    if ({pipe_en, pipe_rst, tx_start, done, tx_data} !== 12'h000)
      $display("FAIL reset_outputs: got %03h, expected 000", {pipe_en, pipe_rst, tx_start, done, tx_data});
    else pass_cnt++;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_run_halt;
    int lows;
    send_cmd(8'h63);
    check1("run_pipe_en_next", pipe_en, 1'b1);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pipe_en !== 1'b1) lows++;
    end
    total_cnt++;
    if (lows != 0) $display("FAIL run_hold: got %0d low cycles, expected 0", lows);
    else pass_cnt++;
    send_cmd(8'h68);
    check1("halt_cmd_pipe_en", pipe_en, 1'b0);
  endtask

  task automatic test_halt_collision;
    send_cmd(8'h63);
    repeat (3) @(negedge clk);
    halt_wb = 1'b1; rx_data = 8'h63; rx_valid = 1'b1;
    @(negedge clk);
    halt_wb = 1'b0; rx_valid = 1'b0;
    check1("collision_done", done, 1'b1);
    check1("collision_pipe_en", pipe_en, 1'b0);
    send_cmd(8'h63);
    check1("done_ignores_c", pipe_en, 1'b0);
    send_cmd(8'h73);
    check1("done_ignores_s", pipe_en, 1'b0);
  endtask

  task automatic test_reset_cmd;
    send_cmd(8'h72);
    model_cnt = 32'd0;
    check1("r_pipe_rst_pulse", pipe_rst, 1'b1);
    check1("r_done_clear", done, 1'b0);
    @(negedge clk);
    check1("r_pipe_rst_one_cycle", pipe_rst, 1'b0);
    send_cmd(8'h63);
    check1("c_after_r", pipe_en, 1'b1);
    repeat (2) @(negedge clk);
    send_cmd(8'h72);
    model_cnt = 32'd0;
    check1("r_in_run_pulse", pipe_rst, 1'b1);
    check1("r_in_run_stops", pipe_en, 1'b0);
  endtask

  task automatic test_step;
    int highs;
    highs = 0;
    for (int k = 0; k < 3; k++) begin
      send_cmd(8'h73);
      if (pipe_en === 1'b1) highs++;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        if (pipe_en === 1'b1) highs++;
      end
    end
    total_cnt++;
    if (highs != 3) $display("FAIL step_pulses: got %0d enabled cycles, expected 3", highs);
    else pass_cnt++;
  endtask

  task automatic test_dump;
    int base;
    bit ok;
    base = bytes_seen;
    pc_value = 32'h0040_0010;
    push_dump(pc_value);
    send_cmd(8'h64);
    pc_value = 32'hDEAD_BEEF;
    check1("send_pipe_en", pipe_en, 1'b0);
    send_cmd(8'h63);
    check1("send_drops_cmd", pipe_en, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && tx_busy == 1'b0) begin ok = 1'b1; break; end
    end
    total_cnt++;
    if (!ok) $display("FAIL dump_timeout: got %0d bytes left, expected 0", exp_q.size());
    else pass_cnt++;
    total_cnt++;
    if (bytes_seen - base != NB) $display("FAIL dump_count: got %0d bytes, expected %0d", bytes_seen - base, NB);
    else pass_cnt++;
    send_cmd(8'h73);
    check1("idle_after_dump", pipe_en, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_abort_dump;
    int base;
    bit ok;
    base = bytes_seen;
    pc_value = 32'h1234_5678;
    push_dump(pc_value);
    send_cmd(8'h64);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bytes_seen - base >= 2) begin ok = 1'b1; break; end
    end
    total_cnt++;
    if (!ok) $display("FAIL abort_wait: got %0d bytes, expected 2", bytes_seen - base);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    exp_q.delete();
    model_cnt = 32'd0;
    total_cnt++;
    if ({pipe_en, pipe_rst, tx_start, done, tx_data} !== 12'h000)
      $display("FAIL abort_outputs: got %03h, expected 000", {pipe_en, pipe_rst, tx_start, done, tx_data});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    total_cnt++;
    if (bytes_seen - base != 2) $display("FAIL abort_no_more_tx: got %0d bytes, expected 2", bytes_seen - base);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_run_halt();
    test_halt_collision();
    test_reset_cmd();
    test_step();
    test_dump();
    test_abort_dump();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_debug_ctrl.md
PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port reset, input, 1: asynchronous active-low reset.
REQ-004 Port rx_data, input, 8: received command byte, qualified by rx_valid.
REQ-005 Port rx_valid, input, 1: one-cycle strobe; rx_data is valid this cycle.
REQ-006 Port tx_busy, input, 1: the UART transmitter is sending.
REQ-007 Port halt_wb, input, 1: a halt instruction has reached writeback this cycle.
REQ-008 Port pc_value, input, 32: current program counter of the datapath.
REQ-009 Port pipe_en, output, 1: enables the PC and all pipeline latches; 0 freezes the datapath.
REQ-010 Port pipe_rst, output, 1: one-cycle active-high reset pulse to the PC, the latches and the register file.
REQ-011 Port tx_data, output, 8: byte to transmit, held stable from tx_start until the next tx_start.
REQ-012 Port tx_start, output, 1: one-cycle strobe that launches the transmission of tx_data.
REQ-013 Port done, output, 1: sticky flag; the program has halted.

Function
REQ-014 The block SHALL implement the states IDLE, RUN, STEP and SEND; all outputs SHALL be registered.
REQ-015 Commands SHALL be accepted only when rx_valid=1 and the state is IDLE or RUN; other bytes SHALL be ignored, and all bytes received in STEP or SEND SHALL be dropped.
REQ-016 Command 0x63 'c' in IDLE with done=0 SHALL enter RUN; pipe_en SHALL be 1 from the next cycle.
REQ-017 Command 0x73 's' in IDLE with done=0 SHALL enter STEP; pipe_en SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-018 Command 0x68 'h' in RUN SHALL enter IDLE; pipe_en SHALL be 0 from the next cycle.
REQ-019 halt_wb=1 in RUN or STEP SHALL set done and enter IDLE, with pipe_en 0 from the next cycle.
REQ-020 If halt_wb and a command arrive in the same cycle, halt_wb SHALL win and the command SHALL be discarded.
REQ-021 Commands 'c' and 's' while done=1 SHALL be ignored.
REQ-022 Command 0x72 'r' in IDLE or RUN SHALL:
- pulse pipe_rst for one cycle;
- clear done and the cycle counter;
- enter IDLE.
REQ-023 Command 0x64 'd' in IDLE SHALL latch pc_value into a snapshot and enter SEND.
REQ-024 SEND SHALL transmit the snapshot as 4 bytes, MSB first.
REQ-025 In SEND, the first tx_start SHALL be issued when tx_busy=0.
REQ-026 Each later tx_start SHALL be issued only after tx_busy has been observed 1 and then 0 following the previous tx_start.
REQ-027 After the last byte's tx_busy falls, the block SHALL return to IDLE.
REQ-028 pipe_en SHALL be 0 in IDLE and SEND.
REQ-029 A 32-bit cycle counter SHALL increment on every cycle with pipe_en=1 and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 On reset=0 the block SHALL set: state IDLE, pipe_en=0, pipe_rst=0, tx_start=0, tx_data=0x00, done=0, snapshot=0, cycle counter=0, byte index=0.
REQ-031 Reset asserted mid-SEND SHALL abort the transfer immediately, with no further tx_start.
REQ-032 After reset release, the first command SHALL be accepted no earlier than the first rising clock edge.

Configuration
REQ-033 With DEBUG_CYCLE_COUNT_EN defined, the 'd' command SHALL send 8 bytes: the PC snapshot, then the cycle counter latched with it, each MSB first.
REQ-034 Without DEBUG_CYCLE_COUNT_EN, the counter SHALL be absent and 'd' SHALL send 4 bytes.

Verification
REQ-035 Reset, then 'c' -> pipe_en=1 from the cycle after the strobe; 'h' after 10 cycles -> pipe_en=0 on the next cycle.
REQ-036 Send 's' three times in IDLE -> exactly 3 single-cycle pipe_en pulses; with the macro on, the counter reads 3.
REQ-037 In RUN, halt_wb=1 and 'c' in the same cycle -> done=1, pipe_en=0, and a later 'c' is ignored until 'r'.
REQ-038 pc_value=0x0040_0010, 'd', tx_busy modelled 1 for 20 cycles after each start -> bytes 0x00, 0x40, 0x00, 0x10 in order, then IDLE; with the macro on, 8 bytes.
REQ-039 'r' while done=1 -> one-cycle pipe_rst, done=0, counter=0; a following 'c' is accepted.
REQ-040 Assert reset after the 2nd byte of a dump -> no further tx_start, all outputs at reset values.
